// File: rtl/prm_edge_mask_if.sv
// prm_edge_mask_if: table-load, sweep-control and result-stream bundle of the edge mask engine
interface prm_edge_mask_if #(
   parameter int IN_W       = 15,
   parameter int NUM_EDGES  = 1024,
   parameter int TERMS_EDGE = 128,
   parameter int LANES      = 4
);
   localparam int EW = $clog2(NUM_EDGES);
   localparam int AW = $clog2(NUM_EDGES * TERMS_EDGE / LANES);
   localparam int DW = LANES * (1 + 2 * IN_W);
   logic          tbl_we;
   logic [AW-1:0] tbl_addr;
   logic [DW-1:0] tbl_data;
   logic          start;
   logic [IN_W-1:0] occ;
   logic          abort;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [EW-1:0] out_edge;
   logic          out_mask;
   logic          done;
   logic [EW:0]   blk_count;
   modport master (
      output tbl_we, tbl_addr, tbl_data, start, occ, abort, out_ready,
      input  busy, out_valid, out_edge, out_mask, done, blk_count
   );
   modport slave (
      input  tbl_we, tbl_addr, tbl_data, start, occ, abort, out_ready,
      output busy, out_valid, out_edge, out_mask, done, blk_count
   );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine: sweeps every PRM edge's sum-of-products term table against a latched
// occupancy vector and streams one blocked/free bit per edge
module prm_edge_mask_engine #(
   parameter int IN_W       = 15,
   parameter int NUM_EDGES  = 1024,
   parameter int TERMS_EDGE = 128,
   parameter int LANES      = 4
) (
   input logic clk,
   input logic rst,
   prm_edge_mask_if.slave bus
);
   localparam int EW = $clog2(NUM_EDGES);
   localparam int G  = TERMS_EDGE / LANES;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int TW = 1 + 2 * IN_W;
   localparam int DW = LANES * TW;
   localparam int AW = $clog2(NUM_EDGES * G);
   typedef enum logic [2:0] {IDLE, FETCH, CMP, EMIT, DONE} state_t;
   state_t state, state_n;
   logic [DW-1:0] mem [NUM_EDGES*G];
   logic [DW-1:0] rd_q;
   logic [IN_W-1:0] occ_q;
   logic [EW-1:0] edge_q;
   logic [GW-1:0] grp_q;
   logic mask_q;
   logic [EW:0] blk_q;
   logic [AW-1:0] rd_addr;
   logic hit, last_grp, last_edge, hs, busy;
   assign rd_addr   = AW'(edge_q) * AW'(G) + AW'(grp_q);
   assign last_grp  = grp_q == GW'(G - 1);
   assign last_edge = edge_q == EW'(NUM_EDGES - 1);
   assign hs        = state == EMIT && bus.out_ready;
   assign busy      = state != IDLE && state != DONE;
   always_comb begin
      hit = 1'b0;
      for (int l = 0; l < LANES; l++)
         hit |= rd_q[l*TW+2*IN_W] &&
                ((occ_q & rd_q[l*TW+IN_W +: IN_W]) == (rd_q[l*TW +: IN_W] & rd_q[l*TW+IN_W +: IN_W]));
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start ? FETCH : IDLE;
         FETCH:   state_n = CMP;
         CMP:     state_n = (hit || last_grp) ? EMIT : FETCH;
         EMIT:    state_n = hs ? (last_edge ? DONE : FETCH) : EMIT;
         default: state_n = IDLE;
      endcase
      // DONE always falls back to IDLE so done stays a single-cycle pulse
      if (bus.abort && busy)
         state_n = DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         occ_q  <= '0;
         edge_q <= '0;
         grp_q  <= '0;
         mask_q <= 1'b0;
         blk_q  <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.start) begin
            occ_q  <= bus.occ;
            edge_q <= '0;
            grp_q  <= '0;
            blk_q  <= '0;
         end
         if (state == CMP) begin
            if (hit || last_grp)
               mask_q <= hit;
            else
               grp_q <= grp_q + 1'b1;
         end
         if (hs) begin
            grp_q <= '0;
            if (mask_q && blk_q != (EW+1)'(NUM_EDGES))
               blk_q <= blk_q + 1'b1;
            if (!last_edge)
               edge_q <= edge_q + 1'b1;
         end
      end
   end
   // term table is deliberately outside reset so a reset does not wipe the loaded roadmap
   always_ff @(posedge clk) begin
      if (bus.tbl_we && !busy)
         mem[bus.tbl_addr] <= bus.tbl_data;
      if (state == FETCH)
         rd_q <= mem[rd_addr];
   end
   assign bus.busy      = busy;
   assign bus.out_valid = state == EMIT;
   assign bus.out_edge  = edge_q;
   assign bus.out_mask  = mask_q;
   assign bus.done      = state == DONE;
   assign bus.blk_count = blk_q;
endmodule
